// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full-flag generator for a dual-clock asynchronous FIFO.
// Keeps the binary and Gray write pointers, and drives the RAM write address.
// Produces a registered full flag from the synchronised Gray read pointer.
// Also produces a fill level, an almost-full flag and a sticky overflow flag.
// The Gray full comparison assumes ADDR_WIDTH >= 2.
module fifo_wptr_full #(
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    input  logic                  wclr_ovf,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  woverflow
);

    localparam int AW = ADDR_WIDTH;
    localparam logic [AW:0] AFULL_THRESH_C = (AW+1)'(AFULL_THRESH);

    // Gray to binary: each binary bit is the XOR of all Gray bits from the MSB down to it.
    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Binary to Gray: adjacent codes differ in exactly one bit.
    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [AW:0] wbin_r;
    logic [AW:0] wptr_r;
    logic        wfull_r;
    logic        walmost_full_r;
    logic [AW:0] wlevel_r;
    logic        woverflow_r;

    logic        wen_s;
    logic [AW:0] wbin_next_s;
    logic [AW:0] wgray_next_s;
    logic [AW:0] rbin_sync_s;
    logic [AW:0] level_next_s;
    logic        full_next_s;
    logic        afull_next_s;
    logic        ovf_next_s;

    // Next-state pointer arithmetic, full comparison, level and overflow decisions.
    always_comb begin
        wen_s        = winc & ~wfull_r;
        wbin_next_s  = wbin_r + {{AW{1'b0}}, wen_s};
        wgray_next_s = bin2gray(wbin_next_s);
        rbin_sync_s  = gray2bin(wq2_rptr);
        level_next_s = wbin_next_s - rbin_sync_s;
        // Full when the next write pointer is one lap ahead of the read pointer:
        // in Gray terms the two MSBs are inverted and the rest match.
        full_next_s  = (wgray_next_s == {~wq2_rptr[AW:AW-1], wq2_rptr[AW-2:0]});
        afull_next_s = (level_next_s >= AFULL_THRESH_C);
        // A dropped write sets the sticky flag and takes priority over a clear.
        if (winc && wfull_r) begin
            ovf_next_s = 1'b1;
        end else if (wclr_ovf) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = woverflow_r;
        end
    end

    // State registers for pointers and flags, cleared asynchronously.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_r         <= {(AW+1){1'b0}};
            wptr_r         <= {(AW+1){1'b0}};
            wfull_r        <= 1'b0;
            walmost_full_r <= 1'b0;
            wlevel_r       <= {(AW+1){1'b0}};
            woverflow_r    <= 1'b0;
        end else begin
            wbin_r         <= wbin_next_s;
            wptr_r         <= wgray_next_s;
            wfull_r        <= full_next_s;
            walmost_full_r <= afull_next_s;
            wlevel_r       <= level_next_s;
            woverflow_r    <= ovf_next_s;
        end
    end

    assign waddr        = wbin_r[AW-1:0];
    assign wptr         = wptr_r;
    assign wfull        = wfull_r;
    assign walmost_full = walmost_full_r;
    assign wlevel       = wlevel_r;
    assign woverflow    = woverflow_r;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full. The reference model counts writes and reads
// as plain integers; expected outputs are queued per clock and checked by a monitor.
module tb_fifo_wptr_full;

    logic       wclk;
    logic       wrst_n;
    logic       winc;
    logic [4:0] wq2_rptr;
    logic       wclr_ovf;

    logic [3:0] waddr,  waddr16;
    logic [4:0] wptr,   wptr16;
    logic       wfull,  wfull16;
    logic       wafull, wafull16;
    logic [4:0] wlevel, wlevel16;
    logic       wovf,   wovf16;

    fifo_wptr_full #(.ADDR_WIDTH(4), .AFULL_THRESH(12)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
        .wclr_ovf(wclr_ovf), .waddr(waddr), .wptr(wptr), .wfull(wfull),
        .walmost_full(wafull), .wlevel(wlevel), .woverflow(wovf)
    );

    fifo_wptr_full #(.ADDR_WIDTH(4), .AFULL_THRESH(16)) dut16 (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
        .wclr_ovf(wclr_ovf), .waddr(waddr16), .wptr(wptr16), .wfull(wfull16),
        .walmost_full(wafull16), .wlevel(wlevel16), .woverflow(wovf16)
    );

    typedef struct {
        logic [3:0] waddr;
        logic [4:0] wptr;
        logic       full;
        logic       afull;
        logic       afull16;
        logic [4:0] level;
        logic       ovf;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: total writes accepted and total reads seen, as plain counts.
    int wcnt = 0;
    int rcnt = 0;
    bit m_full = 1'b0;
    bit m_ovf  = 1'b0;

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        wcnt   = 0;
        rcnt   = 0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
    endtask

    // One write-clock cycle: drive inputs, advance the model, queue the expectation.
    task automatic step(input bit inc, input int rc, input bit clr);
        exp_t e;
        int   lvl;
        bit   wen;
        winc     = inc;
        wclr_ovf = clr;
        rcnt     = rc;
        wq2_rptr = gray(rc[4:0]);
        wen = inc && !m_full;
        if (inc && m_full) m_ovf = 1'b1;
        else if (clr)      m_ovf = 1'b0;
        if (wen) wcnt++;
        lvl    = wcnt - rc;
        m_full = (lvl == 16);
        e.waddr   = wcnt[3:0];
        e.wptr    = gray(wcnt[4:0]);
        e.full    = m_full;
        e.afull   = (lvl >= 12);
        e.afull16 = (lvl >= 16);
        e.level   = lvl[4:0];
        e.ovf     = m_ovf;
        @(posedge wclk);
        sb.push_back(e);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_waddr"}, waddr, 0);
        check({tag, "_wptr"},  wptr, 0);
        check({tag, "_wfull"}, wfull, 0);
        check({tag, "_wafull"}, wafull, 0);
        check({tag, "_wlevel"}, wlevel, 0);
        check({tag, "_wovf"},  wovf, 0);
        check({tag, "_wfull16"}, wfull16, 0);
    endtask

    // Monitor: outputs are valid every cycle after a queued edge; compare on the falling edge.
    always @(negedge wclk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("waddr",   waddr,    e.waddr);
            check("wptr",    wptr,     e.wptr);
            check("wfull",   wfull,    e.full);
            check("wafull",  wafull,   e.afull);
            check("wlevel",  wlevel,   e.level);
            check("wovf",    wovf,     e.ovf);
            check("wfull16", wfull16,  e.full);
            check("wafull16", wafull16, e.afull16);
        end
    end

    initial begin
        logic [4:0] prev_wptr;
        int rc;
        wrst_n   = 1'b0;
        winc     = 1'b0;
        wclr_ovf = 1'b0;
        wq2_rptr = 5'd0;
        #2;
        check_reset_values("rst0");
        #10;
        wrst_n = 1'b1;
        model_reset();

        // Fill from empty: almost-full at the 12th write, full at the 16th.
        for (int i = 0; i < 16; i++) step(1'b1, 0, 1'b0);
        check("fill_wptr", wptr, 5'b11000);
        check("fill_full16_afull_same_edge", {wfull16, wafull16}, 2'b11);

        // Writes while full are dropped and latch overflow; set beats clear.
        for (int i = 0; i < 3; i++) step(1'b1, 0, 1'b0);
        step(1'b1, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);

        // One read frees a slot; one write refills it at address 0.
        step(1'b0, 1, 1'b0);
        check("free_waddr", waddr, 0);
        step(1'b1, 1, 1'b0);
        check("refill_wptr", wptr, 5'b11001);

        // Reads trail writes by two entries across pointer wrap.
        step(1'b0, wcnt - 2, 1'b0);
        prev_wptr = wptr;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, wcnt - 1, 1'b0);
            check("gray_one_bit", $countones(wptr ^ prev_wptr), 1);
            prev_wptr = wptr;
        end

        // Randomised traffic with varying read pressure.
        for (int i = 0; i < 600; i++) begin
            int rdp;
            rdp = (i < 200) ? 1 : ((i < 400) ? 3 : 2);
            rc  = rcnt;
            if (rc < wcnt && $urandom_range(0, 3) < rdp) rc = rc + 1;
            step(($urandom_range(0, 3) != 0), rc, ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset between edges while writes are in flight.
        @(negedge wclk);
        #2;
        winc   = 1'b1;
        wrst_n = 1'b0;
        #1;
        check_reset_values("rst_async");
        @(posedge wclk);
        #2;
        check_reset_values("rst_hold");
        wrst_n = 1'b1;
        wq2_rptr = 5'd0;
        model_reset();
        check("post_rst_waddr", waddr, 0);
        for (int i = 0; i < 5; i++) step(1'b1, 0, 1'b0);
        step(1'b0, 0, 1'b0);

        @(negedge wclk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
Write-side pointer and full-flag generator for the dual-clock asynchronous FIFO. It is the partner of the read-side pointer/empty block.
- Keeps the binary and Gray write pointers and drives the RAM write address.
- Compares the next Gray write pointer against the read pointer, already synchronised into the write domain by the 2-flop synchroniser, to produce a registered full flag.
- Also provides a fill level, an almost-full flag and a sticky overflow error flag.

Parameters:
ADDR_WIDTH, 4, RAM address width; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
AFULL_THRESH, 12, fill level at or above which walmost_full asserts; legal range 1..2**ADDR_WIDTH.

Ports:
wclk  input  1  write-domain clock; single clock for the whole block.
wrst_n  input  1  asynchronous active-low reset.
winc  input  1  write request; accepted only when wfull=0.
wq2_rptr  input  ADDR_WIDTH+1  Gray read pointer, synchronised into wclk.
wclr_ovf  input  1  clears woverflow.
waddr  output  ADDR_WIDTH  RAM write address, equal to wbin[ADDR_WIDTH-1:0].
wptr  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchroniser.
wfull  output  1  registered full flag.
walmost_full  output  1  registered, asserted when level >= AFULL_THRESH.
wlevel  output  ADDR_WIDTH+1  registered fill level, 0..2**ADDR_WIDTH.
woverflow  output  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset (asynchronous, wrst_n=0): wbin=0, wptr=0, waddr=0, wfull=0, walmost_full=0, wlevel=0, woverflow=0. These values hold until the first wclk edge after release.
- Write accept: wen = winc & ~wfull.
- Next-state arithmetic:
  - wbin_next = wbin + wen, modulo 2**(ADDR_WIDTH+1).
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - wptr <= wgray_next.
  - waddr follows wbin, so the write data for the current accepted write goes to the current waddr.
- Full flag:
  - Full when wgray_next == {~wq2_rptr[AW:AW-1], wq2_rptr[AW-2:0]}, where AW = ADDR_WIDTH.
  - wfull is registered from this comparison, so it asserts on the same edge that accepts the last free slot. Zero added latency.
  - wfull deasserts only after the read pointer advance reaches wq2_rptr, two or more wclk cycles after the read. This is pessimistic by design and must never under-report.
- Level:
  - rbin_sync = Gray-to-binary of wq2_rptr, computed as a prefix XOR from the MSB down.
  - wlevel <= wbin_next - rbin_sync, modulo 2**(ADDR_WIDTH+1).
  - wlevel = 2**ADDR_WIDTH exactly when wfull=1.
- Almost full: walmost_full <= (wbin_next - rbin_sync) >= AFULL_THRESH.
- Overflow:
  - When winc=1 and wfull=1, the write is dropped: pointers unchanged, nothing written, and woverflow is set.
  - wclr_ovf=1 clears woverflow on the next edge.
  - If set and clear occur in the same cycle, set wins.
- Wrap-around: pointers wrap from 2**(AW+1)-1 to 0 naturally. The Gray code guarantees a single-bit change per increment.
- Simultaneous write while the read pointer advances: the comparison uses the current wq2_rptr. Full is evaluated on the post-increment pointer.
- Reset mid-operation: all state clears immediately, asynchronously. The read side must be reset in the same system reset.

Test Plan:
1. Reset, hold wq2_rptr=5'b00000, then 16 consecutive winc -> waddr steps 0..15. walmost_full=1 from the edge of the 12th write (wlevel=12). wfull=1 on the edge of the 16th write. wptr=5'b11000 (Gray of 16). wlevel=16.
2. From the full state, pulse winc for 3 cycles -> wptr, waddr and wlevel unchanged. woverflow=1 and stays 1. Assert wclr_ovf together with winc -> woverflow stays 1. wclr_ovf alone -> woverflow=0.
3. From the full state, set wq2_rptr=5'b00001 (Gray of 1) -> wfull=0 and wlevel=15 on the next edge. One winc -> wfull=1, waddr was 0, wptr=Gray(17)=5'b11001.
4. Wrap: drive wq2_rptr to track writes with a 2-entry lag over 40 writes -> wptr changes exactly one bit per write. wbin wraps 31->0. wfull never asserts. wlevel stays at 2.
5. Assert wrst_n low asynchronously mid-burst, between clock edges -> all outputs go to reset values immediately. First write after release uses waddr=0.
6. AFULL_THRESH=16 override -> walmost_full and wfull assert on the same edge.
